// File: rtl/fetch_ctrl_if.sv
// Instruction-bus handshake between the fetch controller and memory.
// master: fetch side (req/addr out); slave: bus side (addr_ok/data_ok/rdata out).
interface fetch_ctrl_if;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;

  modport master (
    output inst_req_o,
    output inst_addr_o,
    input  inst_addr_ok_i,
    input  inst_data_ok_i,
    input  inst_rdata_i
  );

  modport slave (
    input  inst_req_o,
    input  inst_addr_o,
    output inst_addr_ok_i,
    output inst_data_ok_i,
    output inst_rdata_i
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Pre-IF fetch controller: one outstanding bus request, one-entry buffer.
// Ports: clk, rst (async active-low), stall/redirect in, bus master, IF-reg outputs.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          redirect_i,
  input  logic [31:0]   redirect_pc_i,
  fetch_ctrl_if.master  bus,
  output logic [31:0]   preif_pc_o,
  output logic          preif_adel_o,
  output logic [31:0]   inst_o,
  output logic          if_wr_o,
  output logic          if_flush_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } buf_t;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_inc;
  buf_t        r_buf;
  buf_t        w_buf_nxt;
  logic        w_mis;
  logic        w_req;
  logic        w_wr;
  logic        w_free;

  assign w_mis    = |r_pc[1:0];
  assign w_pc_inc = r_pc + 32'd4;
  assign w_req    = (r_state == S_REQ) & ~w_mis;
  assign w_wr     = r_buf.v & ~stall_i & ~redirect_i;
  assign w_free   = ~r_buf.v | w_wr;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_buf_nxt   = r_buf;
    if (w_wr) w_buf_nxt.v = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (redirect_i) begin
          w_pc_nxt    = redirect_pc_i;
          w_buf_nxt.v = 1'b0;
          w_state_nxt = S_REQ;
        end else if (w_free) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect_i) begin
          w_pc_nxt    = redirect_pc_i;
          w_buf_nxt.v = 1'b0;
          // An accepted request must still have its data drained.
          w_state_nxt = (w_req & bus.inst_addr_ok_i)
                      ? S_DROP : S_REQ;
        end else if (w_mis) begin
          w_buf_nxt   = '{v: 1'b1, pc: r_pc,
                          inst: 32'h0, adel: 1'b1};
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_IDLE;
        end else if (bus.inst_addr_ok_i) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          w_pc_nxt    = redirect_pc_i;
          w_buf_nxt.v = 1'b0;
          w_state_nxt = bus.inst_data_ok_i
                      ? S_REQ : S_DROP;
        end else if (bus.inst_data_ok_i) begin
          w_buf_nxt   = '{v: 1'b1, pc: r_pc,
                          inst: bus.inst_rdata_i,
                          adel: 1'b0};
          w_pc_nxt    = w_pc_inc;
          // The entry just loaded occupies the buffer next
          // cycle; IDLE restarts fetch once it drains.
          w_state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (redirect_i) w_pc_nxt = redirect_pc_i;
        if (bus.inst_data_ok_i) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  assign bus.inst_req_o  = w_req;
  assign bus.inst_addr_o = r_pc;

  assign preif_pc_o   = r_buf.v ? r_buf.pc : 32'h0;
  assign inst_o       = r_buf.v ? r_buf.inst : 32'h0;
  assign preif_adel_o = r_buf.v & r_buf.adel;
  assign if_wr_o      = w_wr;
  // Held low while reset is asserted.
  assign if_flush_o   = redirect_i & rst;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random traffic.
// Deliveries are checked against an in-order expected-PC model and a memory image.
module tb_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] preif_pc_o;
  logic        preif_adel_o;
  logic [31:0] inst_o;
  logic        if_wr_o;
  logic        if_flush_o;

  fetch_ctrl_if bus();

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .bus          (bus),
    .preif_pc_o   (preif_pc_o),
    .preif_adel_o (preif_adel_o),
    .inst_o       (inst_o),
    .if_wr_o      (if_wr_o),
    .if_flush_o   (if_flush_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  logic [31:0] exp_pc;
  logic        pend;
  logic [31:0] pend_addr;
  int          idle_cnt;
  logic        prev_req;
  logic        prev_aok;
  logic        prev_rd;
  logic [31:0] prev_addr;

  logic        q_req;
  logic [31:0] q_addr;
  logic        q_wr;
  logic [31:0] q_pc;
  logic [31:0] q_inst;
  logic        q_adel;
  logic        q_flush;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h9BC0_0001;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc(input logic st, input logic rd,
                     input logic [31:0] rpc,
                     input logic aen, input logic den);
    logic mis;
    #1;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    bus.inst_addr_ok_i = bus.inst_req_o & aen;
    bus.inst_data_ok_i = pend & den;
    bus.inst_rdata_i   = (pend & den) ? mem(pend_addr)
                                      : 32'hDEAD_BEEF;
    @(negedge clk);
    q_req   = bus.inst_req_o;
    q_addr  = bus.inst_addr_o;
    q_wr    = if_wr_o;
    q_pc    = preif_pc_o;
    q_inst  = inst_o;
    q_adel  = preif_adel_o;
    q_flush = if_flush_o;
    check("flush", 32'(q_flush), 32'(rd));
    if (rd) check("wr_on_redirect", 32'(q_wr), 32'(0));
    if (q_req) check("req_align", 32'(q_addr[1:0]), 32'(0));
    if (prev_req && !prev_aok && !prev_rd) begin
      check("req_hold", 32'(q_req), 32'(1));
      check("addr_hold", q_addr, prev_addr);
    end
    if (!q_wr && !st && !rd) begin
      check("empty_pc", q_pc, 32'h0);
      check("empty_inst", q_inst, 32'h0);
      check("empty_adel", 32'(q_adel), 32'(0));
    end
    if (q_wr) begin
      mis = (exp_pc[1:0] != 2'b00);
      check("pc", q_pc, exp_pc);
      check("adel", 32'(q_adel), 32'(mis));
      check("inst", q_inst, mis ? 32'h0 : mem(exp_pc));
      exp_pc   = exp_pc + 32'd4;
      idle_cnt = 0;
    end else begin
      idle_cnt++;
    end
    if (rd) exp_pc = rpc;
    if (bus.inst_data_ok_i) pend = 1'b0;
    if (q_req && bus.inst_addr_ok_i) begin
      pend      = 1'b1;
      pend_addr = q_addr;
    end
    prev_req  = q_req;
    prev_aok  = bus.inst_addr_ok_i;
    prev_rd   = rd;
    prev_addr = q_addr;
    @(posedge clk);
  endtask

  task automatic run_until_wr(input int max);
    int n;
    n = 0;
    do begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n++;
    end while (!q_wr && n < max);
    if (!q_wr) check("wr_timeout", 32'(q_wr), 32'(1));
  endtask

  task automatic chk_reset_outs(input string tag);
    check({tag, "_req"}, 32'(bus.inst_req_o), 32'(0));
    check({tag, "_addr"}, bus.inst_addr_o, RST_PC);
    check({tag, "_wr"}, 32'(if_wr_o), 32'(0));
    check({tag, "_pc"}, preif_pc_o, 32'h0);
    check({tag, "_inst"}, inst_o, 32'h0);
    check({tag, "_adel"}, 32'(preif_adel_o), 32'(0));
    check({tag, "_flush"}, 32'(if_flush_o), 32'(0));
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    exp_pc = RST_PC; pend = 1'b0; pend_addr = '0;
    idle_cnt = 0; prev_req = 1'b0; prev_aok = 1'b0;
    prev_rd = 1'b0; prev_addr = '0;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    bus.inst_addr_ok_i = 1'b0;
    bus.inst_data_ok_i = 1'b0;
    bus.inst_rdata_i   = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 chk_reset_outs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);

    // First fetch and delivery after reset.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("first_req", 32'(q_req), 32'(1));
    check("first_addr", q_addr, RST_PC);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("first_wr", 32'(q_wr), 32'(1));
    check("first_pc", q_pc, RST_PC);
    check("first_inst", q_inst, 32'h2400_0001);

    // Stall with a full buffer.
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check("second_addr", q_addr, 32'hBFC0_0004);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      check("stall_wr", 32'(q_wr), 32'(0));
      check("stall_req", 32'(q_req), 32'(0));
      check("stall_pc", q_pc, 32'hBFC0_0004);
      check("stall_inst", q_inst, mem(32'hBFC0_0004));
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("unstall_wr", 32'(q_wr), 32'(1));
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("resume_req", 32'(q_req), 32'(1));
    check("resume_addr", q_addr, 32'hBFC0_0008);

    // Redirect while waiting for data.
    cyc(1'b0, 1'b1, 32'h8000_0100, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("drop_req", 32'(q_req), 32'(0));
    cyc(1'b0, 1'b1, 32'h8000_0102, 1'b0, 1'b1);
    check("redir_req", 32'(q_req), 32'(1));
    check("redir_addr", q_addr, 32'h8000_0100);

    // Misaligned redirect target.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("adel_noreq", 32'(q_req), 32'(0));
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("adel_wr", 32'(q_wr), 32'(1));
    check("adel_pc", q_pc, 32'h8000_0102);
    check("adel_flag", 32'(q_adel), 32'(1));
    check("adel_inst", q_inst, 32'h0);

    // Redirect coincident with data_ok, then with addr_ok.
    cyc(1'b0, 1'b1, 32'h8000_0200, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("r200_addr", q_addr, 32'h8000_0200);
    cyc(1'b0, 1'b1, 32'h8000_0300, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 32'h8000_0400, 1'b1, 1'b0);
    check("r300_addr", q_addr, 32'h8000_0300);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("drop2_req", 32'(q_req), 32'(0));
    run_until_wr(20);
    check("r400_pc", q_pc, 32'h8000_0400);
    check("r400_inst", q_inst, mem(32'h8000_0400));

    // Reset during WAIT, late data_ok afterwards.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    #3 rst = 1'b0;
    stall_i = 1'b0; redirect_i = 1'b0;
    bus.inst_addr_ok_i = 1'b0;
    bus.inst_data_ok_i = 1'b0;
    #1 chk_reset_outs("wait_rst");
    exp_pc = RST_PC; prev_req = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("late_req", 32'(q_req), 32'(1));
    check("late_addr", q_addr, RST_PC);
    run_until_wr(20);
    check("late_pc", q_pc, RST_PC);
    check("late_inst", q_inst, 32'h2400_0001);

    // PC wrap-around.
    cyc(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    run_until_wr(20);
    check("wrap0_pc", q_pc, 32'hFFFF_FFF8);
    run_until_wr(20);
    check("wrap1_pc", q_pc, 32'hFFFF_FFFC);
    run_until_wr(20);
    check("wrap2_pc", q_pc, 32'h0000_0000);

    // Random traffic.
    idle_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      logic        st;
      logic        rd;
      logic [31:0] t;
      st = ($urandom % 4) == 0;
      rd = ($urandom % 16) == 0;
      t  = $urandom & 32'hFFFF_FFFC;
      if (($urandom % 4) == 0) t[1:0] = 2'($urandom);
      cyc(st, rd, t, 1'(($urandom % 3) != 0),
          1'($urandom % 2));
      if (idle_cnt > 100) begin
        check("progress", 32'(idle_cnt), 32'(0));
        idle_cnt = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
